bicubic_window_feeder: RTL and testbench

BICUBIC_WINDOW_FEEDER -- requirements
Module: bicubic_window_feeder

---
 rtl/bicubic_window_feeder.sv | 99 +++++++++
 tb/tb_bicubic_window_feeder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bicubic_window_feeder.sv
// bicubic_window_feeder: 4-line vertical window feeder for a bicubic core; define WINDOW_COUNT_EN to add the window_count output
module bicubic_window_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    input  logic                  sof,
    output logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] row0_out,
    output logic [DATA_WIDTH-1:0] row1_out,
    output logic [DATA_WIDTH-1:0] row2_out,
    output logic [DATA_WIDTH-1:0] row3_out,
    output logic                  shift_window,
`ifdef WINDOW_COUNT_EN
    output logic [15:0]           window_count,
`endif
    output logic                  frame_done
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
    state_t r_state, w_next;
    logic [XW-1:0] r_x, w_x_next, w_col;
    logic [YW-1:0] r_y, w_y_next;
    logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
    logic w_accept, w_take, w_emit, w_last_x, w_last_y;
    assign pix_ready  = r_state != DONE;
    assign frame_done = r_state == DONE;
    assign w_accept   = pix_valid && pix_ready;
    assign w_take     = w_accept && (r_state != IDLE || sof);
    assign w_emit     = w_accept && !sof && r_state == STREAM;
    assign w_col      = sof ? '0 : r_x;
    assign w_last_x   = r_x == XW'(IMG_WIDTH - 1);
    assign w_last_y   = r_y == YW'(IMG_HEIGHT - 1);
    always_comb begin
        w_next   = r_state;
        w_x_next = r_x;
        w_y_next = r_y;
        if (r_state == DONE) begin
            w_next = IDLE;
        end else if (w_take && sof) begin
            w_next   = FILL;
            w_x_next = XW'(1);
            w_y_next = '0;
        end else if (w_take) begin
            w_x_next = w_last_x ? '0 : r_x + 1'b1;
            w_y_next = !w_last_x ? r_y : (w_last_y ? '0 : r_y + 1'b1);
            if (r_state == FILL && w_last_x && r_y == YW'(2))
                w_next = STREAM;
            if (r_state == STREAM && w_last_x && w_last_y)
                w_next = DONE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            shift_window <= 1'b0;
            row0_out     <= '0;
            row1_out     <= '0;
            row2_out     <= '0;
            row3_out     <= '0;
        end else begin
            r_state      <= w_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            shift_window <= w_emit;
            if (w_emit) begin
                row0_out <= r_lb0[r_x];
                row1_out <= r_lb1[r_x];
                row2_out <= r_lb2[r_x];
                row3_out <= pix_in;
            end
        end
    end
    // Line buffers keep their contents across reset and sof; FILL hides stale lines.
    always_ff @(posedge clk) begin
        if (!rst && w_take) begin
            r_lb0[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= r_lb2[w_col];
            r_lb2[w_col] <= pix_in;
        end
    end
`ifdef WINDOW_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || (w_accept && sof))
            window_count <= '0;
        else if (shift_window && window_count != 16'hFFFF)
            window_count <= window_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_bicubic_window_feeder.sv
// tb_bicubic_window_feeder: directed checks of the window feeder on a 4x6 frame with pixel = 16*y + x
`timescale 1ns/1ps
module tb_bicubic_window_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = 8'h00;
    logic       pix_valid = 1'b1;
    logic       sof = 1'b1;
    logic       pix_ready, shift_window, frame_done;
    logic [7:0] row0_out, row1_out, row2_out, row3_out;
`ifdef WINDOW_COUNT_EN
    logic [15:0] window_count;
`endif
    int n_pass = 0;
    int n_total = 0;
    int pulses;

    bicubic_window_feeder #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(6)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .pix_ready(pix_ready), .row0_out(row0_out), .row1_out(row1_out),
        .row2_out(row2_out), .row3_out(row3_out), .shift_window(shift_window),
`ifdef WINDOW_COUNT_EN
        .window_count(window_count),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rows();
        return {row0_out, row1_out, row2_out, row3_out};
    endfunction

    function automatic logic [31:0] exp_rows(input int x, input int y);
        return {8'(16*(y-3)+x), 8'(16*(y-2)+x), 8'(16*(y-1)+x), 8'(16*y+x)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic px(input int v, input bit s);
        pix_valid = 1'b1;
        pix_in    = 8'(v);
        sof       = s;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        sof       = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic frame(input bit gapped, input int start, output int npulse);
        npulse = 0;
        for (int i = start; i < 24; i++) begin
            px(16*(i/4) + i%4, i == 0);
            chk("shift", shift_window, 32'(i >= 12));
            if (shift_window) npulse++;
            if (i >= 12) chk("rows", rows(), exp_rows(i%4, i/4));
            if (i == 23) begin
                chk("done_pulse", frame_done, 1);
                chk("done_ready", pix_ready, 0);
            end
            if (gapped) begin
                idle();
                chk("gap_shift", shift_window, 0);
            end
        end
        idle();
        chk("after_done", frame_done, 0);
        chk("after_ready", pix_ready, 1);
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_rows", rows(), 0);
        chk("rst_shift", shift_window, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ready", pix_ready, 1);
        @(posedge clk); #1;
        chk("rst2_rows", rows(), 0);
        chk("rst2_shift", shift_window, 0);
        chk("rst2_ready", pix_ready, 1);
`ifdef WINDOW_COUNT_EN
        chk("rst_count", window_count, 0);
`endif
        rst = 1'b0;
        idle();

        frame(1'b0, 0, pulses);
        chk("cont_pulses", pulses, 12);
`ifdef WINDOW_COUNT_EN
        chk("frame_count", window_count, 12);
`endif
        frame(1'b1, 0, pulses);
        chk("gap_pulses", pulses, 12);

        for (int i = 0; i < 3; i++) begin
            px(8'h99, 1'b0);
            chk("discard_shift", shift_window, 0);
        end
        frame(1'b0, 0, pulses);
        chk("discard_pulses", pulses, 12);

        for (int i = 0; i < 17; i++) begin
            px(16*(i/4) + i%4, i == 0);
            chk("pre_restart_shift", shift_window, 32'(i >= 12));
        end
        px(8'h00, 1'b1);
        chk("restart_shift", shift_window, 0);
`ifdef WINDOW_COUNT_EN
        chk("restart_count", window_count, 0);
`endif
        frame(1'b0, 1, pulses);
        chk("restart_pulses", pulses, 12);

        for (int i = 0; i < 14; i++) px(16*(i/4) + i%4, i == 0);
        rst = 1'b1;
        px(8'h77, 1'b0);
        chk("midrst_rows", rows(), 0);
        chk("midrst_shift", shift_window, 0);
`ifdef WINDOW_COUNT_EN
        chk("midrst_count", window_count, 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            px(8'h55, 1'b0);
            chk("post_rst_discard", shift_window, 0);
        end
        frame(1'b0, 0, pulses);
        chk("post_rst_pulses", pulses, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
